// File: rtl/dt_reg_writeback_pkg.sv
// Shared definitions for the Dt write-back slice: register index map,
// default register counts and the pair-stager state encoding.
package dt_reg_writeback_pkg;

    localparam int DEF_N_BYTE_REGS = 11;
    localparam int DEF_N_PAIRS     = 4;

    // Byte register bit positions in notPI_WriteDt_byte / notByteRegs
    localparam int IDX_A    = 0;
    localparam int IDX_F    = 1;
    localparam int IDX_B    = 2;
    localparam int IDX_C    = 3;
    localparam int IDX_D    = 4;
    localparam int IDX_E    = 5;
    localparam int IDX_H    = 6;
    localparam int IDX_L    = 7;
    localparam int IDX_OP   = 8;
    localparam int IDX_DT   = 9;
    localparam int IDX_DTEX = 10;

    // Pair register positions in the pair strobes / notPairRegs
    localparam int PAIR_PC = 0;
    localparam int PAIR_IX = 1;
    localparam int PAIR_IY = 2;
    localparam int PAIR_SP = 3;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HELD = 1'b1
    } stager_state_e;

endpackage

// File: rtl/dt_pair_stager.sv
// Pair-load staging FSM: holds a low byte until the matching high byte
// arrives so a 16-bit pair is never written half-updated. Produces
// per-pair byte write enables and write data for the storage in the top.
module dt_pair_stager
    import dt_reg_writeback_pkg::*;
#(
    parameter int N_PAIRS = DEF_N_PAIRS
) (
    input  logic                     clock,
    input  logic                     notReset,
    input  logic [7:0]               Dt,
    input  logic [N_PAIRS-1:0]       notPI_WriteDt_pair_low,
    input  logic [N_PAIRS-1:0]       notPI_WriteDt_pair_high,
    input  logic                     notPI_PairAbort,
    output logic [N_PAIRS-1:0]       pair_we_lo,
    output logic [N_PAIRS-1:0]       pair_we_hi,
    output logic [N_PAIRS-1:0][15:0] pair_wdata,
    output logic                     pairPending,
    output logic [1:0]               pendingPair
);

    stager_state_e state_q, state_d;
    logic [7:0]    stage_q, stage_d;
    logic [1:0]    target_q, target_d;

    logic [N_PAIRS-1:0] low, high, both, low_only;
    logic               abort_held;
    logic               stage_hit;
    logic [1:0]         stage_idx;
    logic               commit;

    // Decode strobes; a same-cycle low+high on one pair is a direct full
    // write, so only low-only strobes are staging candidates (lowest wins)
    always_comb begin
        low        = ~notPI_WriteDt_pair_low;
        high       = ~notPI_WriteDt_pair_high;
        both       = low & high;
        low_only   = low & ~high;
        abort_held = (state_q == ST_HELD) && !notPI_PairAbort;
        stage_hit  = 1'b0;
        stage_idx  = 2'd0;
        for (int p = N_PAIRS - 1; p >= 0; p--) begin
            if (low_only[p]) begin
                stage_hit = 1'b1;
                stage_idx = 2'(p);
            end
        end
        commit = (state_q == ST_HELD) && !abort_held
                 && high[target_q] && !low[target_q];
    end

    // Per-pair write enables; an abort suppresses the commit of the target
    always_comb begin
        for (int p = 0; p < N_PAIRS; p++) begin
            pair_we_hi[p] = high[p] & ~(abort_held & ~low[p] & (target_q == 2'(p)));
            pair_we_lo[p] = both[p] | (commit & (target_q == 2'(p)));
            pair_wdata[p] = {Dt, (both[p] ? Dt : stage_q)};
        end
    end

    // Next state: abort beats everything, a direct full write drops any stage,
    // a new low byte (re)stages, otherwise a commit returns to idle
    always_comb begin
        state_d  = state_q;
        stage_d  = stage_q;
        target_d = target_q;
        if (abort_held) begin
            state_d = ST_IDLE;
        end else if (|both) begin
            state_d = ST_IDLE;
        end else if (stage_hit) begin
            state_d  = ST_HELD;
            stage_d  = Dt;
            target_d = stage_idx;
        end else if (commit) begin
            state_d = ST_IDLE;
        end
    end

    // FSM, stage byte and target pair registers
    always_ff @(posedge clock or negedge notReset) begin
        if (!notReset) begin
            state_q  <= ST_IDLE;
            stage_q  <= 8'd0;
            target_q <= 2'd0;
        end else begin
            state_q  <= state_d;
            stage_q  <= stage_d;
            target_q <= target_d;
        end
    end

    assign pairPending = (state_q == ST_HELD);
    assign pendingPair = target_q;

endmodule

// File: rtl/dt_reg_writeback.sv
// Dt bus write-back: byte and pair register storage, driven back out
// inverted to the Dt read mux. Pair loads go through dt_pair_stager.
// Optional macro PC_INCREMENT_EN adds notPI_IncPC, a PC +1 strobe that
// yields to any PC write in the same cycle.
module dt_reg_writeback
    import dt_reg_writeback_pkg::*;
#(
    parameter int N_BYTE_REGS = DEF_N_BYTE_REGS,
    parameter int N_PAIRS     = DEF_N_PAIRS
) (
    input  logic                       clock,
    input  logic                       notReset,
`ifdef PC_INCREMENT_EN
    input  logic                       notPI_IncPC,
`endif
    input  logic [7:0]                 Dt,
    input  logic [N_BYTE_REGS-1:0]     notPI_WriteDt_byte,
    input  logic [N_PAIRS-1:0]         notPI_WriteDt_pair_low,
    input  logic [N_PAIRS-1:0]         notPI_WriteDt_pair_high,
    input  logic                       notPI_PairAbort,
    output logic [8*N_BYTE_REGS-1:0]   notByteRegs,
    output logic [16*N_PAIRS-1:0]      notPairRegs,
    output logic                       pairPending,
    output logic [1:0]                 pendingPair
);

    logic [N_BYTE_REGS-1:0][7:0] byte_q, byte_d;
    logic [N_PAIRS-1:0][15:0]    pair_q, pair_d;
    logic [N_PAIRS-1:0]          pair_we_lo, pair_we_hi;
    logic [N_PAIRS-1:0][15:0]    pair_wdata;

    dt_pair_stager #(
        .N_PAIRS (N_PAIRS)
    ) u_stager (
        .clock                   (clock),
        .notReset                (notReset),
        .Dt                      (Dt),
        .notPI_WriteDt_pair_low  (notPI_WriteDt_pair_low),
        .notPI_WriteDt_pair_high (notPI_WriteDt_pair_high),
        .notPI_PairAbort         (notPI_PairAbort),
        .pair_we_lo              (pair_we_lo),
        .pair_we_hi              (pair_we_hi),
        .pair_wdata              (pair_wdata),
        .pairPending             (pairPending),
        .pendingPair             (pendingPair)
    );

    // Byte registers: every selected register takes Dt (broadcast allowed)
    always_comb begin
        byte_d = byte_q;
        for (int i = 0; i < N_BYTE_REGS; i++) begin
            if (!notPI_WriteDt_byte[i]) begin
                byte_d[i] = Dt;
            end
        end
    end

    // Pair registers: byte-granular writes from the stager, then the
    // optional PC increment only when PC is not written this cycle
    always_comb begin
        pair_d = pair_q;
        for (int p = 0; p < N_PAIRS; p++) begin
            if (pair_we_hi[p]) begin
                pair_d[p][15:8] = pair_wdata[p][15:8];
            end
            if (pair_we_lo[p]) begin
                pair_d[p][7:0] = pair_wdata[p][7:0];
            end
        end
`ifdef PC_INCREMENT_EN
        if (!notPI_IncPC && !pair_we_lo[PAIR_PC] && !pair_we_hi[PAIR_PC]) begin
            pair_d[PAIR_PC] = pair_q[PAIR_PC] + 16'd1;
        end
`endif
    end

    // Register storage
    always_ff @(posedge clock or negedge notReset) begin
        if (!notReset) begin
            byte_q <= '0;
            pair_q <= '0;
        end else begin
            byte_q <= byte_d;
            pair_q <= pair_d;
        end
    end

    assign notByteRegs = ~byte_q;
    assign notPairRegs = ~pair_q;

endmodule

// File: doc/dt_reg_writeback.md
Name: dt_reg_writeback

Overview:
Write-back end of the Dt data bus. Captures the 8-bit Dt bus into the CPU register file on active-low write strobes from the pipeline interface. Drives every register back out in inverted form (not-prefixed) to the Dt read mux. 16-bit pair registers (PC, IX, IY, SP) are loaded through a staging FSM so a two-byte load never exposes a torn value.

Parameters:
N_BYTE_REGS, 11, number of 8-bit registers (A,F,B,C,D,E,H,L,OP,Dt,Dtex)
N_PAIRS, 4, number of 16-bit pair registers (PC,IX,IY,SP)

Ports:
clock  in  1  single system clock, rising edge
notReset  in  1  asynchronous, active-low reset
Dt  in  8  data bus value to store
notPI_WriteDt_byte  in  N_BYTE_REGS  active-low byte write strobes, bit index per package constant
notPI_WriteDt_pair_low  in  N_PAIRS  active-low low-byte strobes (index 0=PC,1=IX,2=IY,3=SP)
notPI_WriteDt_pair_high  in  N_PAIRS  active-low high-byte strobes
notPI_PairAbort  in  1  active-low: discard staged low byte
notByteRegs  out  8*N_BYTE_REGS  inverted byte registers, reg i at [8i+7:8i]
notPairRegs  out  16*N_PAIRS  inverted pair registers, pair p at [16p+15:16p]
pairPending  out  1  high while a staged low byte awaits its high byte
pendingPair  out  2  index of staged pair (valid when pairPending=1)

Behaviour:
- Reset (async, notReset=0): all stored registers 0 → notByteRegs all ones, notPairRegs all ones; FSM IDLE; pairPending=0; pendingPair=0. Releasing reset takes effect at the next rising edge.
- Outputs are registered inversions of storage. A write at edge k is visible on the outputs after edge k.
- Byte writes: every i with notPI_WriteDt_byte[i]=0 at the edge loads Dt. Simultaneous strobes broadcast Dt to all selected registers.
- Pair staging FSM, states IDLE and HELD. Registers: stage[7:0], target[1:0].
- IDLE, low strobe on pair p: stage<=Dt, target<=p, go to HELD. The pair register is unchanged.
- Low strobes on several pairs: the lowest index wins and the others are ignored.
- HELD, high strobe on target: pair[target]<={Dt,stage}, go to IDLE.
- High strobe on pair q (IDLE, or HELD with q≠target): pair[q][15:8]<=Dt, low byte kept. FSM state is unchanged.
- HELD, low strobe on any pair: restage. stage<=Dt and target updated; the previous stage is discarded. Stay in HELD.
- Low and high strobe on the same pair in the same cycle, in either state: pair<={Dt,Dt}, go to IDLE, discard any stage.
- notPI_PairAbort=0 in HELD: go to IDLE with no write. Abort has priority over low-strobe restage and over commit.
- pairPending = (state==HELD); pendingPair = target.

Optional Feature:
PC_INCREMENT_EN
- Compiled in: adds input notPI_IncPC (1, active-low). On the edge where it is low, PC<=PC+1 mod 2^16 (FFFF→0000).
- Any PC pair write or commit in the same cycle takes priority and the increment is dropped.
- An increment while PC is staged in HELD leaves the stage intact; a later commit overwrites the whole PC.
- Compiled out: no port and no incrementer; PC changes only via writes.

Decomposition:
- Shared package holds: byte-register index constants (IDX_A=0 … IDX_DTEX=10), pair index constants (PAIR_PC=0 … PAIR_SP=3), N_BYTE_REGS/N_PAIRS defaults, and the FSM state encoding (IDLE=0, HELD=1).
- One sub-module, dt_pair_stager: owns the FSM, stage and target. It outputs a per-pair write-enable and 16-bit write data, plus pairPending/pendingPair.
- The top level holds the storage and the inversion.

Test Plan:
- Reset then byte writes: Dt=8'h3C with A strobe low → after edge notByteRegs[7:0]=8'hC3; all other outputs remain 8'hFF.
- Staged pair load: low IX with Dt=8'h34, next cycle high IX with Dt=8'h12 → IX shows 16'hFFFF until the commit edge, then notPairRegs[31:16]=16'hEDCB; pairPending goes 1 then 0.
- Abort and restage: low SP with 8'hAA, then low SP with 8'h55, then high SP with 8'h01 → SP=16'h0155. Separately, low SP then abort → SP unchanged, pairPending=0.
- Simultaneous low+high on PC with Dt=8'h7E → PC=16'h7E7E in one edge, FSM stays IDLE.
- Reset mid-operation: HELD on IY, assert notReset=0 asynchronously → pairPending drops immediately without a clock and IY output is 16'hFFFF.
- PC_INCREMENT_EN: PC=16'hFFFF, notPI_IncPC low → PC=16'h0000. Increment and PC high write with Dt=8'h80 in the same cycle → high byte takes 8'h80, low byte unchanged, no increment.
